// File: rtl/rb_cmd_if.sv
//==============================================================================
// rb_cmd_if: host byte link and register-bank bus seen by the command initiator.
// Rev 1.0
//==============================================================================
`default_nettype none

interface rb_cmd_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [ADDR_W-1:0] rb_addr;
   logic [DATA_W-1:0] rb_wdata;
   logic              rb_wr;
   logic              rb_rd;
   logic [DATA_W-1:0] rb_rdata;
   logic              rb_rvalid;

   modport master (
      input  rx_data, rx_valid, tx_ready, rb_rdata, rb_rvalid,
      output rx_ready, tx_data, tx_valid, rb_addr, rb_wdata, rb_wr, rb_rd
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, rb_rdata, rb_rvalid,
      input  rx_ready, tx_data, tx_valid, rb_addr, rb_wdata, rb_wr, rb_rd
   );
endinterface

`default_nettype wire

// File: rtl/rb_cmd_initiator.sv
//==============================================================================
// rb_cmd_initiator: decodes host command bytes into register-bank write/read strobes.
// Rev 1.0
//==============================================================================
`default_nettype none

module rb_cmd_initiator #(
   parameter int         ADDR_W       = 7,
   parameter int         DATA_W       = 8,
   parameter int         TIMEOUT      = 16,
   parameter logic [7:0] TIMEOUT_BYTE = 8'hEE
) (
   input  wire logic clk,
   input  wire logic rst,
   rb_cmd_if.master  bus,
   output logic      busy,
   output logic      err_timeout,
   input  wire logic err_clr
);

   localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [2:0] c_IDLE      = 3'd0;
   localparam logic [2:0] c_GET_DATA  = 3'd1;
   localparam logic [2:0] c_WRITE     = 3'd2;
   localparam logic [2:0] c_READ_REQ  = 3'd3;
   localparam logic [2:0] c_READ_WAIT = 3'd4;
   localparam logic [2:0] c_SEND      = 3'd5;

   logic [2:0]         state_q, state_d;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [7:0]         txd_q;
   logic [c_CNT_W-1:0] cnt_q;
   logic               err_q;

   logic w_rx_ready, w_tx_valid, w_rb_wr, w_rb_rd, w_busy;
   logic w_rx_fire, w_cnt_last, w_timeout;

   assign w_rx_fire  = bus.rx_valid & w_rx_ready;
   assign w_cnt_last = (cnt_q == c_CNT_W'(TIMEOUT - 1));
   // Bank data arriving on the final wait cycle beats the timeout.
   assign w_timeout  = (state_q == c_READ_WAIT) & ~bus.rb_rvalid & w_cnt_last;

   always_ff @(posedge clk) begin
      if (rst) state_q <= c_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE:      if (w_rx_fire) state_d = bus.rx_data[7] ? c_READ_REQ : c_GET_DATA;
         c_GET_DATA:  if (w_rx_fire) state_d = c_WRITE;
         c_WRITE:     state_d = c_IDLE;
         c_READ_REQ:  state_d = c_READ_WAIT;
         c_READ_WAIT: if (bus.rb_rvalid || w_cnt_last) state_d = c_SEND;
         c_SEND:      if (bus.tx_ready) state_d = c_IDLE;
         default:     state_d = c_IDLE;
      endcase
   end

   // rx_ready is masked by rst so no byte is taken while reset is held.
   always_comb begin
      w_rx_ready = 1'b0;
      w_tx_valid = 1'b0;
      w_rb_wr    = 1'b0;
      w_rb_rd    = 1'b0;
      w_busy     = 1'b1;
      case (state_q)
         c_IDLE: begin
            w_rx_ready = ~rst;
            w_busy     = 1'b0;
         end
         c_GET_DATA: w_rx_ready = ~rst;
         c_WRITE:    w_rb_wr    = 1'b1;
         c_READ_REQ: w_rb_rd    = 1'b1;
         c_SEND:     w_tx_valid = 1'b1;
         default:    w_busy     = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         txd_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (state_q == c_IDLE && w_rx_fire)
            addr_q <= bus.rx_data[ADDR_W-1:0];
         if (state_q == c_GET_DATA && w_rx_fire)
            wdata_q <= bus.rx_data[DATA_W-1:0];
         if (state_q == c_READ_REQ)
            cnt_q <= '0;
         else if (state_q == c_READ_WAIT)
            cnt_q <= cnt_q + 1'b1;
         if (state_q == c_READ_WAIT) begin
            if (bus.rb_rvalid) txd_q <= bus.rb_rdata;
            else if (w_cnt_last) txd_q <= TIMEOUT_BYTE;
         end
         if (w_timeout)    err_q <= 1'b1;
         else if (err_clr) err_q <= 1'b0;
      end
   end

   assign bus.rx_ready = w_rx_ready;
   assign bus.tx_valid = w_tx_valid;
   assign bus.tx_data  = txd_q;
   assign bus.rb_addr  = addr_q;
   assign bus.rb_wdata = wdata_q;
   assign bus.rb_wr    = w_rb_wr;
   assign bus.rb_rd    = w_rb_rd;
   assign busy         = w_busy;
   assign err_timeout  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_rb_cmd_initiator.sv
//==============================================================================
// tb_rb_cmd_initiator: scoreboard bench with a register-bank model for rb_cmd_initiator.
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_rb_cmd_initiator;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic err_clr = 1'b0;
   logic busy, err_timeout;

   rb_cmd_if #(.ADDR_W(7), .DATA_W(8)) bus ();

   rb_cmd_initiator #(.ADDR_W(7), .DATA_W(8), .TIMEOUT(TIMEOUT), .TIMEOUT_BYTE(8'hEE)) dut (
      .clk(clk), .rst(rst), .bus(bus), .busy(busy),
      .err_timeout(err_timeout), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct { logic [6:0] a; logic [7:0] d; } wr_t;
   wr_t        exp_wr[$];
   logic [6:0] exp_rd[$];
   logic [7:0] exp_tx[$];
   logic [7:0] exp_mem[128];

   // ---------------- register bank model ----------------
   logic [7:0] mem[128];
   int         rd_lat = 3;
   bit         bank_mute = 0, spur = 0, bpend = 0;
   int         bwait = 0;
   logic [6:0] baddr;

   always begin
      @(posedge clk);
      if (rst) bpend = 0;
      else begin
         if (bus.rb_wr) mem[bus.rb_addr] = bus.rb_wdata;
         if (bus.rb_rd && !bank_mute) begin
            bpend = 1; bwait = rd_lat - 1; baddr = bus.rb_addr;
         end
      end
      #1;
      bus.rb_rvalid = 1'b0;
      if (spur) begin
         bus.rb_rvalid = 1'b1; bus.rb_rdata = 8'h55;
      end else if (bpend) begin
         if (bwait == 0) begin
            bus.rb_rvalid = 1'b1; bus.rb_rdata = mem[baddr]; bpend = 0;
         end else bwait--;
      end
   end

   // ---------------- monitor ----------------
   int   wr_cnt = 0, rd_cnt = 0, last_wr_cyc = 0, last_rd_cyc = 0;
   int   tx_rise_cyc = 0, tx_hs_cyc = 0;
   logic prev_wr = 0, prev_rd = 0, prev_txv = 0, prev_txr = 0;
   logic [7:0] prev_txd = 0;
   wr_t  mon_e;

   always @(negedge clk) begin
      if (rst) begin
         prev_wr = 0; prev_rd = 0; prev_txv = 0; prev_txr = 0;
      end else begin
         if (bus.rb_wr && bus.rb_rd) check("strobes_overlap", 1, 0);
         if (bus.rb_wr) begin
            wr_cnt++; last_wr_cyc = cyc;
            if (prev_wr) check("wr_two_cycles", 1, 0);
            if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
            else begin
               mon_e = exp_wr.pop_front();
               check("wr_addr", bus.rb_addr, mon_e.a);
               check("wr_data", bus.rb_wdata, mon_e.d);
            end
         end
         if (bus.rb_rd) begin
            rd_cnt++; last_rd_cyc = cyc;
            if (prev_rd) check("rd_two_cycles", 1, 0);
            if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
            else check("rd_addr", bus.rb_addr, exp_rd.pop_front());
         end
         if (bus.tx_valid && !prev_txv) tx_rise_cyc = cyc;
         if (prev_txv && !prev_txr) begin
            check("tx_valid_held", bus.tx_valid, 1);
            check("tx_data_stable", bus.tx_data, prev_txd);
         end
         if (bus.tx_valid) check("rx_ready_in_send", bus.rx_ready, 0);
         if (bus.tx_valid && bus.tx_ready) begin
            tx_hs_cyc = cyc;
            if (exp_tx.size() == 0) check("tx_unexpected", 1, 0);
            else check("tx_data", bus.tx_data, exp_tx.pop_front());
         end
         prev_wr = bus.rb_wr; prev_rd = bus.rb_rd;
         prev_txv = bus.tx_valid; prev_txr = bus.tx_ready; prev_txd = bus.tx_data;
      end
   end

   // ---------------- stimulus helpers (called at posedge+1) ----------------
   task automatic send_byte(input logic [7:0] b, output int hs);
      logic fire;
      bus.rx_data = b; bus.rx_valid = 1'b1; hs = -1;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         fire = bus.rx_ready;
         if (fire) hs = cyc;
         #1;
         if (fire) break;
      end
      if (hs < 0) check("rx_accept_timeout", 1, 0);
   endtask

   task automatic wait_quiet();
      bit ok = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!busy && exp_wr.size() == 0 && exp_rd.size() == 0 && exp_tx.size() == 0) begin
            ok = 1; break;
         end
      end
      if (!ok) check("quiet_timeout", 1, 0);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_ready"}, bus.rx_ready, 0);
      check({tag, "_tx_valid"}, bus.tx_valid, 0);
      check({tag, "_tx_data"},  bus.tx_data, 0);
      check({tag, "_rb_wr"},    bus.rb_wr, 0);
      check({tag, "_rb_rd"},    bus.rb_rd, 0);
      check({tag, "_rb_addr"},  bus.rb_addr, 0);
      check({tag, "_rb_wdata"}, bus.rb_wdata, 0);
      check({tag, "_busy"},     busy, 0);
      check({tag, "_err"},      err_timeout, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int h, h2, hs01, hx, wr0, str0, mism;
      logic [6:0] a;
      logic [7:0] d;
      bus.rx_data = 0; bus.rx_valid = 0; bus.tx_ready = 1;
      bus.rb_rvalid = 0; bus.rb_rdata = 0;
      for (int i = 0; i < 128; i++) begin
         mem[i] = 8'(i * 7 + 3); exp_mem[i] = 8'(i * 7 + 3);
      end
      mem[3] = 8'h3C; exp_mem[3] = 8'h3C;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      check("idle_rx_ready", bus.rx_ready, 1);
      @(posedge clk); #1;

      // write 0x05 <- 0xA7
      send_byte(8'h05, h);
      send_byte(8'hA7, h2);
      bus.rx_valid = 0;
      exp_wr.push_back('{a: 7'h05, d: 8'hA7}); exp_mem[5] = 8'hA7;
      wait_quiet();
      check("wr_latency", last_wr_cyc - h2, 1);
      check("wr_count", wr_cnt, 1);

      // read 0x03, bank answers 3 cycles after rb_rd
      rd_lat = 3;
      send_byte(8'h83, h);
      bus.rx_valid = 0;
      exp_rd.push_back(7'h03); exp_tx.push_back(8'h3C);
      wait_quiet();
      check("rd_latency", last_rd_cyc - h, 1);
      check("rd_to_txvalid", tx_rise_cyc - last_rd_cyc, 4);
      check("rd_no_err", err_timeout, 0);

      // backpressure: tx_ready low 10 cycles, next command waits
      bus.tx_ready = 0;
      send_byte(8'h83, h);
      bus.rx_valid = 0;
      exp_rd.push_back(7'h03); exp_tx.push_back(8'h3C);
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               @(negedge clk);
               if (bus.tx_valid) break;
            end
            repeat (10) @(posedge clk);
            #1 bus.tx_ready = 1;
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            send_byte(8'h01, hs01);
            send_byte(8'h99, hx);
            bus.rx_valid = 0;
            exp_wr.push_back('{a: 7'h01, d: 8'h99}); exp_mem[1] = 8'h99;
         end
      join
      wait_quiet();
      check("bp_hold_cycles", tx_hs_cyc - tx_rise_cyc, 10);
      check("bp_rx_after_tx", hs01 - tx_hs_cyc, 1);

      // read timeout
      bank_mute = 1;
      send_byte(8'h90, h);
      bus.rx_valid = 0;
      exp_rd.push_back(7'h10); exp_tx.push_back(8'hEE);
      wait_quiet();
      check("to_latency", tx_rise_cyc - last_rd_cyc, TIMEOUT + 1);
      check("to_err_set", err_timeout, 1);
      err_clr = 1;
      @(posedge clk); #1 err_clr = 0;
      @(negedge clk);
      check("to_err_clr", err_timeout, 0);
      @(posedge clk); #1;
      bank_mute = 0;

      // bank data on the final wait cycle wins over timeout
      rd_lat = TIMEOUT;
      send_byte(8'h90, h);
      bus.rx_valid = 0;
      exp_rd.push_back(7'h10); exp_tx.push_back(exp_mem[16]);
      wait_quiet();
      check("edge_latency", tx_rise_cyc - last_rd_cyc, TIMEOUT + 1);
      check("edge_no_err", err_timeout, 0);

      // stray rb_rvalid while idle is ignored
      spur = 1;
      repeat (3) @(posedge clk);
      #1 spur = 0;
      @(negedge clk);
      check("spur_busy", busy, 0);
      check("spur_tx_valid", bus.tx_valid, 0);
      @(posedge clk); #1;

      // reset in GET_DATA
      wr0 = wr_cnt;
      send_byte(8'h22, h);
      bus.rx_valid = 0;
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst_getdata");
      @(posedge clk); #1 rst = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_getdata_no_wr", wr_cnt, wr0);

      // reset in READ_WAIT
      bank_mute = 1;
      send_byte(8'h85, h);
      bus.rx_valid = 0;
      exp_rd.push_back(7'h05);
      repeat (4) @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst_readwait");
      @(posedge clk); #1 rst = 0;
      bank_mute = 0;

      // write after reset completes normally
      send_byte(8'h07, h);
      send_byte(8'h5D, h2);
      bus.rx_valid = 0;
      exp_wr.push_back('{a: 7'h07, d: 8'h5D}); exp_mem[7] = 8'h5D;
      wait_quiet();
      check("post_rst_wr", wr_cnt, wr0 + 1);
      check("post_rst_latency", last_wr_cyc - h2, 1);

      // 50 back-to-back commands with rx_valid held high
      str0 = wr_cnt + rd_cnt;
      for (int n = 0; n < 50; n++) begin
         a = 7'($urandom_range(0, 127));
         d = 8'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            rd_lat = $urandom_range(1, 5);
            send_byte({1'b1, a}, h);
            exp_rd.push_back(a); exp_tx.push_back(exp_mem[a]);
         end else begin
            send_byte({1'b0, a}, h);
            send_byte(d, h2);
            exp_wr.push_back('{a: a, d: d}); exp_mem[a] = d;
         end
      end
      bus.rx_valid = 0;
      wait_quiet();
      check("b2b_strobes", wr_cnt + rd_cnt - str0, 50);
      mism = 0;
      for (int i = 0; i < 128; i++) if (mem[i] !== exp_mem[i]) mism++;
      check("bank_contents", mism, 0);
      check("b2b_no_err", err_timeout, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
